// File: rtl/bmp_frame_writer_if.sv
// Pixel-in / BMP-byte-out signal bundle for bmp_frame_writer.
// The writer connects through the slave modport; the pixel source and byte consumer use master.
interface bmp_frame_writer_if;
   logic       hsync;
   logic [7:0] data_r;
   logic [7:0] data_g;
   logic [7:0] data_b;
   logic [7:0] out_byte;
   logic       out_valid;
   logic       out_ready;
   logic       write_done;

   modport slave (
      input  hsync, data_r, data_g, data_b, out_ready,
      output out_byte, out_valid, write_done
   );

   modport master (
      output hsync, data_r, data_g, data_b, out_ready,
      input  out_byte, out_valid, write_done
   );
endinterface

// File: rtl/bmp_frame_writer.sv
// Captures one RGB888 frame into a bottom-up buffer, then streams it out as a 24-bit BMP file.
// The buffer holds one 24-bit word per pixel; row padding is generated on the output side.
module bmp_frame_writer #(
   parameter int unsigned WIDTH  = 768,
   parameter int unsigned HEIGHT = 512
) (
   input logic               hclk,
   input logic               hreset,
   bmp_frame_writer_if.slave bus
);
   localparam int unsigned ROWBYTES = ((3 * WIDTH + 3) / 4) * 4;
   localparam int unsigned IMGSIZE  = ROWBYTES * HEIGHT;
   localparam int unsigned FILESIZE = 54 + IMGSIZE;
   localparam int unsigned NPIX     = WIDTH * HEIGHT;
   localparam int unsigned AW       = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam int unsigned CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned RW       = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam int unsigned RBW      = $clog2(ROWBYTES + 1);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] CAPTURE = 3'd1;
   localparam logic [2:0] HEADER  = 3'd2;
   localparam logic [2:0] PIXEL   = 3'd3;
   localparam logic [2:0] DONE    = 3'd4;

   function automatic logic [7:0] hdr_byte(input logic [5:0] idx);
      logic [31:0] field;
      int unsigned base;
      field = 32'd0;
      base  = 0;
      case (idx) inside
         [6'd0 : 6'd1]:   begin field = 32'h0000_4D42; base = 0;  end
         [6'd2 : 6'd5]:   begin field = FILESIZE;      base = 2;  end
         [6'd10 : 6'd13]: begin field = 32'd54;        base = 10; end
         [6'd14 : 6'd17]: begin field = 32'd40;        base = 14; end
         [6'd18 : 6'd21]: begin field = WIDTH;         base = 18; end
         [6'd22 : 6'd25]: begin field = HEIGHT;        base = 22; end
         [6'd26 : 6'd27]: begin field = 32'd1;         base = 26; end
         [6'd28 : 6'd29]: begin field = 32'd24;        base = 28; end
         [6'd34 : 6'd37]: begin field = IMGSIZE;       base = 34; end
         [6'd38 : 6'd41]: begin field = 32'd2835;      base = 38; end
         [6'd42 : 6'd45]: begin field = 32'd2835;      base = 42; end
         default:         begin field = 32'd0;         base = 0;  end
      endcase
      return 8'(field >> (8 * (32'(idx) - base)));
   endfunction

   logic [2:0]     state_q;
   logic [CW-1:0]  col_q;
   logic [RW-1:0]  row_q;
   logic [5:0]     hidx_q;
   logic [31:0]    pcnt_q;
   logic [RBW-1:0] rb_q;
   logic [1:0]     lane_q;
   logic [AW-1:0]  raddr_q;
   logic           issued_all_q;
   logic           s1_valid_q, s1_mem_q, s1_last_q;
   logic [7:0]     s1_val_q;
   logic [1:0]     s1_lane_q;
   logic [7:0]     out_byte_q;
   logic           out_valid_q, out_last_q, write_done_q;
   logic [23:0]    mem [NPIX];
   logic [23:0]    rd_word_q;

   logic          capture, last_pix, xfer, s1_move, issue, pad, rd_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    lane_byte;

   always_comb begin
      capture  = bus.hsync && (state_q == IDLE || state_q == CAPTURE);
      last_pix = (col_q == CW'(WIDTH - 1)) && (row_q == RW'(HEIGHT - 1));
      // Top row of the incoming raster lands in the last buffer row.
      wr_addr  = AW'((HEIGHT - 32'd1 - 32'(row_q)) * WIDTH + 32'(col_q));
      xfer     = out_valid_q && bus.out_ready;
      s1_move  = s1_valid_q && (!out_valid_q || xfer);
      issue    = (state_q == HEADER || (state_q == PIXEL && !issued_all_q)) &&
                 (!s1_valid_q || s1_move);
      pad      = rb_q >= RBW'(3 * WIDTH);
      rd_en    = issue && state_q == PIXEL && !pad;
      case (s1_lane_q)
         2'd0:    lane_byte = rd_word_q[7:0];
         2'd1:    lane_byte = rd_word_q[15:8];
         default: lane_byte = rd_word_q[23:16];
      endcase
   end

   always_ff @(posedge hclk) begin
      if (capture) mem[wr_addr] <= {bus.data_r, bus.data_g, bus.data_b};
      if (rd_en) rd_word_q <= mem[raddr_q];
   end

   // Two-stage output: s1 holds the issued byte (and its RAM read), out_* is what the consumer sees.
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state_q      <= IDLE;
         col_q        <= '0;
         row_q        <= '0;
         hidx_q       <= '0;
         pcnt_q       <= '0;
         rb_q         <= '0;
         lane_q       <= '0;
         raddr_q      <= '0;
         issued_all_q <= 1'b0;
         s1_valid_q   <= 1'b0;
         s1_mem_q     <= 1'b0;
         s1_last_q    <= 1'b0;
         s1_val_q     <= '0;
         s1_lane_q    <= '0;
         out_byte_q   <= '0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         write_done_q <= 1'b0;
      end else begin
         if (capture) begin
            if (col_q == CW'(WIDTH - 1)) begin
               col_q <= '0;
               row_q <= row_q + 1'b1;
            end else begin
               col_q <= col_q + 1'b1;
            end
            state_q <= last_pix ? HEADER : CAPTURE;
         end

         if (issue) begin
            s1_valid_q <= 1'b1;
            if (state_q == HEADER) begin
               s1_mem_q  <= 1'b0;
               s1_val_q  <= hdr_byte(hidx_q);
               s1_last_q <= 1'b0;
               hidx_q    <= hidx_q + 1'b1;
               if (hidx_q == 6'd53) state_q <= PIXEL;
            end else begin
               s1_mem_q  <= !pad;
               s1_val_q  <= 8'h00;
               s1_lane_q <= lane_q;
               s1_last_q <= pcnt_q == 32'(IMGSIZE - 1);
               pcnt_q    <= pcnt_q + 1'b1;
               if (pcnt_q == 32'(IMGSIZE - 1)) issued_all_q <= 1'b1;
               rb_q <= (rb_q == RBW'(ROWBYTES - 1)) ? '0 : rb_q + 1'b1;
               if (!pad) begin
                  if (lane_q == 2'd2) begin
                     lane_q  <= '0;
                     raddr_q <= raddr_q + 1'b1;
                  end else begin
                     lane_q <= lane_q + 1'b1;
                  end
               end
            end
         end else if (s1_move) begin
            s1_valid_q <= 1'b0;
         end

         if (s1_move) begin
            out_valid_q <= 1'b1;
            out_byte_q  <= s1_mem_q ? lane_byte : s1_val_q;
            out_last_q  <= s1_last_q;
         end else if (xfer) begin
            out_valid_q <= 1'b0;
         end

         if (xfer && out_last_q) begin
            state_q      <= DONE;
            write_done_q <= 1'b1;
         end
      end
   end

   assign bus.out_byte   = out_byte_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.write_done = write_done_q;
endmodule

// File: doc/bmp_frame_writer.md
# bmp_frame_writer

Sink for the pixel stream produced by the image-reading/processing block: captures one full frame of RGB888 pixels qualified by HSYNC into an internal frame buffer in BMP pixel order (bottom-up rows, B-G-R bytes, rows zero-padded to 4 bytes). Once the frame is complete, it emits a complete 24-bit BMP file (54-byte header plus pixel array) as a byte stream over a valid/ready interface. Its consumer is the testbench file dumper or a downstream storage block.

## Interface
- WIDTH, 768, image width in pixels (≥1)
- HEIGHT, 512, image height in pixels (≥1)
- HCLK  input  1  clock, all logic on rising edge
- HRESET  input  1  asynchronous, active-high reset
- HSYNC  input  1  pixel valid; one pixel accepted per cycle while high
- DATA_R  input  8  red component
- DATA_G  input  8  green component
- DATA_B  input  8  blue component
- OUT_BYTE  output  8  BMP file byte
- OUT_VALID  output  1  OUT_BYTE valid
- OUT_READY  input  1  consumer accepts OUT_BYTE
- WRITE_DONE  output  1  level; high after the last file byte is accepted

## Operation
- Derived: ROWBYTES = 4*ceil(3*WIDTH/4); IMGSIZE = ROWBYTES*HEIGHT; FILESIZE = 54 + IMGSIZE.
- FSM states: IDLE, CAPTURE, HEADER, PIXEL, DONE.
- IDLE: on HSYNC=1, pixel 0 is captured in that cycle; go to CAPTURE. If WIDTH*HEIGHT = 1, go directly to HEADER.
- CAPTURE: each cycle with HSYNC=1 stores a pixel. Cycles with HSYNC=0 are gaps; counters hold.
- Pixel k arrives in raster order, top row first: row = k / WIDTH, col = k % WIDTH. Buffer byte address = (HEIGHT-1-row)*ROWBYTES + 3*col. Bytes are stored B at +0, G at +1, R at +2.
- Track row and col with counters. col wraps at WIDTH-1 and then increments row; no divider is used.
- When pixel WIDTH*HEIGHT-1 is accepted, go to HEADER. HSYNC is ignored in HEADER, PIXEL and DONE.
- HEADER emits 54 bytes. All multi-byte fields are little-endian.
  - Bytes 0-1: 0x42, 0x4D.
  - Bytes 2-5: FILESIZE.
  - Bytes 6-9: 0.
  - Bytes 10-13: 54.
  - Bytes 14-17: 40.
  - Bytes 18-21: WIDTH.
  - Bytes 22-25: HEIGHT.
  - Bytes 26-27: 1.
  - Bytes 28-29: 24.
  - Bytes 30-33: 0.
  - Bytes 34-37: IMGSIZE.
  - Bytes 38-45: 2835 twice.
  - Bytes 46-53: 0.
- PIXEL emits IMGSIZE buffer bytes in address order. Pad bytes (offset within the row ≥ 3*WIDTH) are output as 0x00 regardless of buffer contents.
- After the last pixel byte is accepted, go to DONE. WRITE_DONE=1 and OUT_VALID=0 are held until reset. No second frame is captured.
- Handshake: a byte transfers on a rising edge with OUT_VALID=1 and OUT_READY=1.
  - Once OUT_VALID is asserted, OUT_BYTE stays stable and OUT_VALID stays high until the transfer.
  - OUT_READY may toggle arbitrarily; throughput is one byte per cycle when OUT_READY stays high.
- Arithmetic: byte counter and addresses are wide enough for FILESIZE (32 bits is sufficient). Header fields are computed from parameters at elaboration.

## Timing
- Reset values: OUT_BYTE=0, OUT_VALID=0, WRITE_DONE=0, state IDLE, all counters 0. Buffer contents are not cleared.
- HRESET asserted mid-capture or mid-output: immediately returns to IDLE with outputs at reset values. The next HSYNC after release starts a new frame at pixel 0.
- Capture: zero wait states; a pixel with HSYNC high is written on the same edge.
- Output start: OUT_VALID rises at most 2 cycles after the edge accepting the final pixel, carrying byte 0 (0x42).
- Buffer read is a registered (synchronous) read. The output path prefetches so that no bubble occurs while OUT_READY stays high, including across the HEADER→PIXEL boundary.
- WRITE_DONE rises on the edge after the last accepted byte. OUT_VALID falls on that same edge.

## Test plan
- WIDTH=2, HEIGHT=2, continuous HSYNC with pixels (R,G,B): p0=(1,2,3), p1=(4,5,6), p2=(7,8,9), p3=(10,11,12); OUT_READY=1 → exactly 70 bytes.
  - Bytes 2-5 = 46 00 00 00; bytes 34-37 = 10 00 00 00.
  - Pixel array = 09 08 07 0C 0B 0A 00 00 03 02 01 06 05 04 00 00.
  - WRITE_DONE high after byte 69.
- WIDTH=4, HEIGHT=1, HSYNC with gaps (pattern 1,0,1,1,0,1) → no padding; 66 bytes total; pixels appear in arrival order as BGR.
- Same stream as the first test, OUT_READY random at 50% → byte sequence identical; OUT_BYTE never changes while OUT_VALID=1 and OUT_READY=0.
- Default 768x512 frame from the image-reading block → bytes 2-5 = 36 00 12 00; 1179702 bytes total; bytes 18-21 = 00 03 00 00.
- HRESET pulsed after 3 of 4 pixels (WIDTH=2, HEIGHT=2), then a full new frame → outputs at reset values during reset; output file contains only new-frame data.
- HSYNC toggled during HEADER/PIXEL/DONE → output stream unchanged; WRITE_DONE stays high until reset.
